// File: rtl/waveform_combiner.sv
// Serial NUM_VOICES-voice mixer: snapshot on strobe, one voice added per clock, then scale.
// Optional macro COMB_SAT_EN selects saturating-sum scaling instead of divide-by-NUM_VOICES.
module waveform_combiner #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 8
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           sample_strobe,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic [NUM_VOICES-1:0]          voice_en,
    output logic [SAMPLE_W-1:0]            comb_waveform,
    output logic                           comb_valid,
    output logic                           busy,
    output logic                           overrun
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCALE} state_t;

    state_t                          r_state, w_next;
    logic [NUM_VOICES*SAMPLE_W-1:0]  r_snap;
    logic [NUM_VOICES-1:0]           r_en_snap;
    logic [IDX_W-1:0]                r_idx;
    logic [ACC_W-1:0]                r_acc;
    logic [SAMPLE_W-1:0]             r_comb;
    logic                            r_valid;
    logic                            r_overrun;

    logic [SAMPLE_W-1:0]             w_voice;
    logic [SAMPLE_W-1:0]             w_add;
    logic [SAMPLE_W-1:0]             w_scaled;

    assign w_voice = r_snap[r_idx*SAMPLE_W +: SAMPLE_W];
    assign w_add   = r_en_snap[r_idx] ? w_voice : '0;

`ifdef COMB_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << SAMPLE_W) - 1);
    assign w_scaled = (r_acc > SAT_MAX) ? {SAMPLE_W{1'b1}} : r_acc[SAMPLE_W-1:0];
`else
    // Divide by NUM_VOICES: the top SAMPLE_W bits of the accumulator.
    assign w_scaled = r_acc[ACC_W-1:IDX_W];
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_strobe) w_next = S_ACCUM;
            S_ACCUM: if (r_idx == LAST_IDX) w_next = S_SCALE;
            S_SCALE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_snap    <= '0;
            r_en_snap <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_comb    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            // Strobes outside IDLE (including the SCALE cycle) are dropped and flagged.
            r_overrun <= sample_strobe && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (sample_strobe) begin
                        r_snap    <= voice_samples;
                        r_en_snap <= voice_en;
                        r_acc     <= '0;
                        r_idx     <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + {{IDX_W{1'b0}}, w_add};
                    r_idx <= r_idx + 1'b1;
                end
                S_SCALE: begin
                    r_comb  <= w_scaled;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign comb_waveform = r_comb;
    assign comb_valid    = r_valid;
    assign overrun       = r_overrun;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_waveform_combiner.sv
// Bench for waveform_combiner (NUM_VOICES=4): directed cases plus random mixes against a sum-based model.
module tb_waveform_combiner;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        sample_strobe;
    logic [31:0] voice_samples;
    logic [3:0]  voice_en;
    logic [7:0]  comb_waveform;
    logic        comb_valid;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    waveform_combiner #(.NUM_VOICES(4), .SAMPLE_W(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .sample_strobe (sample_strobe),
        .voice_samples (voice_samples),
        .voice_en      (voice_en),
        .comb_waveform (comb_waveform),
        .comb_valid    (comb_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain sum of the enabled voices, then divide by 4 or clip at 255.
    function automatic int model(input logic [31:0] s, input logic [3:0] en);
        int sum = 0;
        for (int i = 0; i < 4; i++)
            if (en[i]) sum += int'(s[i*8 +: 8]);
`ifdef COMB_SAT_EN
        return (sum > 255) ? 255 : sum;
`else
        return sum / 4;
`endif
    endfunction

    function automatic logic [31:0] pack4(input int v3, input int v2, input int v1, input int v0);
        return {v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
    endfunction

    // Full mix with cycle-exact latency checks; inputs are scrambled once the snapshot is taken.
    task automatic run_mix(input string tag, input logic [31:0] s, input logic [3:0] en);
        int exp_v;
        exp_v = model(s, en);
        @(negedge clk);
        voice_samples = s; voice_en = en; sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        voice_samples = $urandom; voice_en = 4'($urandom);
        check({tag, " busy@E0"}, int'(busy), 1);
        check({tag, " valid@E0"}, int'(comb_valid), 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            voice_samples = $urandom; voice_en = 4'($urandom);
            check({tag, " valid early"}, int'(comb_valid), 0);
            check({tag, " busy mid"}, int'(busy), 1);
        end
        @(negedge clk);
        check({tag, " valid@E5"}, int'(comb_valid), 1);
        check({tag, " result"}, int'(comb_waveform), exp_v);
        check({tag, " busy@E5"}, int'(busy), 0);
        check({tag, " overrun"}, int'(overrun), 0);
        @(negedge clk);
        check({tag, " valid@E6"}, int'(comb_valid), 0);
        check({tag, " hold"}, int'(comb_waveform), exp_v);
    endtask

    initial begin
        logic [31:0] s;
        int exp_v;
        n_rst = 1'b0; sample_strobe = 1'b0; voice_samples = '0; voice_en = '0;
        #12;
        check("rst comb", int'(comb_waveform), 0);
        check("rst valid", int'(comb_valid), 0);
        check("rst busy", int'(busy), 0);
        check("rst overrun", int'(overrun), 0);
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);

        run_mix("all255", pack4(255, 255, 255, 255), 4'b1111);
        check("all255 abs", int'(comb_waveform), 255);
        run_mix("ramp", pack4(40, 30, 20, 10), 4'b1111);
`ifdef COMB_SAT_EN
        check("ramp abs", int'(comb_waveform), 100);
`else
        check("ramp abs", int'(comb_waveform), 25);
`endif
        run_mix("half", pack4(0, 0, 200, 200), 4'b0011);
`ifdef COMB_SAT_EN
        check("half abs", int'(comb_waveform), 255);
`else
        check("half abs", int'(comb_waveform), 100);
`endif
        run_mix("none", pack4(99, 88, 77, 66), 4'b0000);
        check("none abs", int'(comb_waveform), 0);

        // Overrun: second strobe two cycles into the mix, voices forced to 255.
        s = pack4(40, 30, 20, 10);
        exp_v = model(s, 4'b1111);
        @(negedge clk); voice_samples = s; voice_en = 4'b1111; sample_strobe = 1'b1;
        @(negedge clk); sample_strobe = 1'b0; voice_samples = '1;
        @(negedge clk); sample_strobe = 1'b1;
        @(negedge clk); sample_strobe = 1'b0;
        check("ovr pulse", int'(overrun), 1);
        check("ovr busy", int'(busy), 1);
        @(negedge clk);
        check("ovr pulse end", int'(overrun), 0);
        @(negedge clk);
        check("ovr valid early", int'(comb_valid), 0);
        sample_strobe = 1'b1;  // lands on the SCALE edge
        @(negedge clk); sample_strobe = 1'b0;
        check("ovr valid", int'(comb_valid), 1);
        check("ovr result", int'(comb_waveform), exp_v);
        check("ovr busy done", int'(busy), 0);
        check("ovr scale strobe", int'(overrun), 1);
        @(negedge clk);
        check("ovr not accepted", int'(busy), 0);
        check("ovr pulse end2", int'(overrun), 0);
        repeat (10) @(negedge clk);
        check("hold idle", int'(comb_waveform), exp_v);

        // Reset during ACCUM discards the mix.
        @(negedge clk); voice_samples = pack4(255, 255, 255, 255); voice_en = 4'b1111; sample_strobe = 1'b1;
        @(negedge clk); sample_strobe = 1'b0;
        @(negedge clk); n_rst = 1'b0;
        #1;
        check("rst mid comb", int'(comb_waveform), 0);
        check("rst mid busy", int'(busy), 0);
        repeat (5) begin
            @(negedge clk);
            check("rst mid valid", int'(comb_valid), 0);
        end
        n_rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst release valid", int'(comb_valid), 0);
        end
        check("rst release comb", int'(comb_waveform), 0);
        run_mix("post rst", pack4(40, 30, 20, 10), 4'b1111);

        // Random mixes with random idle gaps.
        for (int n = 0; n < 25; n++) begin
            run_mix("rand", $urandom, 4'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
